pci_simple_target: RTL and testbench
====================================

Name: pci_simple_target

Overview:
- Single-function PCI-style target (responder) for the same bus as the team's simple initiator.
- Watches FRAME/IRDY/AD/CBE, claims memory read/write transactions addressed to its window, and drives DEVSEL/TRDY/STOP (all active-low).
- Serves data from a small internal byte-enabled register file.
- Sits beside initiators and the arbiter on the shared bus model; it has no REQ/GNT.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; aligned to 4*2^ADDR_BITS.
- ADDR_BITS, 3, log2 of word depth (8 x 32-bit words).
- DEVSEL_DELAY, 1, edges after the address edge before DEVSEL asserts (0..2).
- WAIT_STATES, 0, TRDY hold-off edges inserted before every data phase (0..3).

Ports:
- clk  in  1  bus clock
- rst  in  1  synchronous reset, active-high
- FRAME  in  1  active-low transaction frame
- IRDY  in  1  active-low initiator ready
- AD_in  in  32  address (address phase) / write data
- CBE  in  4  command (address phase) / active-low byte enables (data phases)
- AD_out  out  32  read data
- AD_oe  out  1  target drives AD
- DEVSEL  out  1  active-low device select
- TRDY  out  1  active-low target ready
- STOP  out  1  active-low stop/disconnect
- I_AM_TARGET  out  1  high while this target owns the current transaction

Behaviour:
- All outputs are registered and change on posedge clk.
- Reset (rst=1 at an edge) sets DEVSEL=1, TRDY=1, STOP=1, AD_oe=0, AD_out=0, I_AM_TARGET=0, all memory words 0, state IDLE. Reset mid-transaction aborts silently: no partial write occurs at that edge.
- Address edge A: FRAME=0 sampled in IDLE with bus idle (FRAME=1 and IRDY=1) at the previous edge.
- Hit condition: AD_in[31:ADDR_BITS+2] equals BASE_ADDR in the same bits, and CBE is 0110 (mem read) or 0111 (mem write). Word offset = AD_in[ADDR_BITS+1:2]; AD_in[1:0] is ignored.
- Miss goes to BUSY: no outputs driven; return to IDLE at the first edge sampling FRAME=1 and IRDY=1.
- States: IDLE, DECODE, TURN, DATA, DISC, BUSY.
- DECODE: waits out DEVSEL_DELAY.
  - DEVSEL=0 and I_AM_TARGET=1 at edge A+DEVSEL_DELAY; with delay 0 this is edge A itself.
- Write timing: TRDY=0 at edge A+DEVSEL_DELAY+WAIT_STATES.
- Read timing:
  - TURN enforces one turnaround: AD_oe=1 no earlier than edge A+1, with AD_out=mem[offset].
  - TRDY=0 at edge max(A+DEVSEL_DELAY, A+1)+WAIT_STATES.
- Transfer: an edge sampling IRDY=0 and TRDY=0.
  - Write: mem[offset] lanes with CBE[i]=0 take AD_in bytes.
  - Read: AD_out is loaded with mem[offset+1] at the same edge.
  - Offset increments after each transfer.
  - IRDY=1 keeps TRDY/AD_out stable; this is an initiator wait and nothing is transferred.
- After a non-final transfer, TRDY goes to 1 for WAIT_STATES edges, then back to 0. With WAIT_STATES=0, TRDY stays 0.
- Final transfer: the transfer edge also samples FRAME=1. At that edge DEVSEL=1, TRDY=1, AD_oe=0, I_AM_TARGET=0 → IDLE.
- Window end: a transfer at offset 2^ADDR_BITS−1 with FRAME=0 still sampled → DISC.
  - At that edge: TRDY=1, STOP=0, DEVSEL stays 0, AD_oe=0.
  - No wrap; no further data is accepted.
  - Leave DISC at the first edge sampling FRAME=1: STOP=1, DEVSEL=1, I_AM_TARGET=0 → IDLE.
- Initiator vanish: FRAME=1 and IRDY=1 sampled in DECODE/TURN/DATA → release everything at that edge → IDLE.
- A write and a read of the same word never coincide (single port); no forwarding is required.

Decomposition:
- Shared package pci_pkg holds:
  - CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111.
  - Target state enum.
  - Active-low ASSERTED/DEASSERTED constants, reused by the initiator and arbiter.
- Sub-module pci_target_mem: 2^ADDR_BITS x 32 register file with synchronous reset-to-zero, per-byte active-low write enables and a combinational read port.

Test Plan:
- Write single (DEVSEL_DELAY=1, WAIT_STATES=0):
  - Stimulus: address 0x0000_1000, CBE=0111; then data 0xDEADBEEF, CBE=0000, IRDY=0, FRAME=1.
  - Response: DEVSEL=0 and TRDY=0 at A+1; transfer at A+2; release at A+2; mem[0]=0xDEADBEEF.
- Read burst (DEVSEL_DELAY=1, WAIT_STATES=0):
  - Stimulus: preload mem[1..3]=0x11,0x22,0x33; read burst of 3 from 0x0000_1004.
  - Response: AD_oe=1 at A+1; AD_out returns 0x11,0x22,0x33 on successive transfer edges; AD_oe=0 after the last.
- Byte enables plus wait states (WAIT_STATES=2, IRDY held 1 for 3 cycles):
  - Stimulus: write 0xAABBCCDD with CBE=1100 to a word holding 0x12345678.
  - Response: word becomes 0x1234CCDD; TRDY asserts at A+DEVSEL_DELAY+2; no transfer while IRDY=1.
- Disconnect:
  - Stimulus: burst write starting at 0x0000_101C, FRAME held low for 2 phases.
  - Response: first word written; same edge TRDY=1, STOP=0; second phase not written; STOP/DEVSEL release the edge after FRAME=1.
- Miss then hit:
  - Stimulus: write to 0x0000_2000, then a write to 0x0000_1000.
  - Response: DEVSEL stays 1 throughout the miss and memory is unchanged; the hit that follows is claimed normally.
- Reset mid-burst:
  - Stimulus: rst=1 during a read data phase.
  - Response: next edge DEVSEL=TRDY=STOP=1, AD_oe=0, I_AM_TARGET=0, memory all zero.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared PCI bus definitions: commands, active-low levels, target states.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_TURN,
    ST_DATA,
    ST_DISC,
    ST_BUSY
  } tgt_state_e;

endpackage

// File: rtl/pci_target_mem.sv
// Target register file: sync reset-to-zero, active-low byte write enables, comb read.
module pci_target_mem #(
  parameter int unsigned ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [3:0]           be_n,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem_q [DEPTH];

  // Byte-lane writes; reset wins so an aborted transfer never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (!be_n[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pci_simple_target.sv
// Single-function PCI-style memory target serving an internal register file.
module pci_simple_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned ADDR_BITS    = 3,
  parameter int unsigned DEVSEL_DELAY = 1,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [31:0] AD_in,
  input  logic [3:0]  CBE,
  output logic [31:0] AD_out,
  output logic        AD_oe,
  output logic        DEVSEL,
  output logic        TRDY,
  output logic        STOP,
  output logic        I_AM_TARGET
);
  localparam int unsigned            CNT_W    = 2;
  localparam int unsigned            TAG_LSB  = ADDR_BITS + 2;
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]       DD_CNT   = CNT_W'(DEVSEL_DELAY);
  localparam logic [CNT_W-1:0]       WS_CNT   = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_BITS-1:0]   OFF_ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0]   OFF_LAST = '1;

  tgt_state_e             state_q, state_d;
  logic [ADDR_BITS-1:0]   off_q, off_d;
  logic                   rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   prev_idle_q;

  logic [31:0]            ad_out_d;
  logic                   ad_oe_d, devsel_d, trdy_d, stop_d, iam_d;

  logic                   addr_hit_c, is_read_c, rd_now_c;
  logic                   xfer_c, vanish_c;
  logic                   claim_c, start_c, release_c;
  logic                   mem_we_c;
  logic [ADDR_BITS-1:0]   mem_raddr_c;
  logic [31:0]            mem_rdata;

  // Address decode and transfer qualifiers.
  assign is_read_c   = (CBE == CMD_MEM_READ);
  assign addr_hit_c  = (AD_in[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                       (is_read_c || (CBE == CMD_MEM_WRITE));
  assign rd_now_c    = (state_q == ST_IDLE) ? is_read_c : rd_q;
  assign xfer_c      = (state_q == ST_DATA) && (TRDY == ASSERTED) && (IRDY == ASSERTED);
  assign vanish_c    = (FRAME == DEASSERTED) && (IRDY == DEASSERTED);
  assign mem_we_c    = xfer_c && !rd_q;
  // A read transfer preloads the following word; otherwise present the current one.
  assign mem_raddr_c = xfer_c ? (off_q + OFF_ONE) : off_q;

  pci_target_mem #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_c),
    .be_n  (CBE),
    .waddr (off_q),
    .wdata (AD_in),
    .raddr (mem_raddr_c),
    .rdata (mem_rdata)
  );

  // Next-state and next-output logic for the target FSM.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ad_out_d  = AD_out;
    ad_oe_d   = AD_oe;
    devsel_d  = DEVSEL;
    trdy_d    = TRDY;
    stop_d    = STOP;
    iam_d     = I_AM_TARGET;
    claim_c   = 1'b0;
    start_c   = 1'b0;
    release_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if ((FRAME == ASSERTED) && prev_idle_q) begin
          if (addr_hit_c) begin
            off_d = AD_in[ADDR_BITS+1:2];
            rd_d  = is_read_c;
            if (DEVSEL_DELAY == 0) begin
              claim_c = 1'b1;
              // Reads need one turnaround edge before driving AD.
              if (is_read_c) state_d = ST_TURN;
              else           start_c = 1'b1;
            end else begin
              cnt_d   = DD_CNT - CNT_ONE;
              state_d = ST_DECODE;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
      end

      ST_DECODE: begin
        if (vanish_c) begin
          release_c = 1'b1;
        end else if (cnt_q == '0) begin
          claim_c = 1'b1;
          start_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_TURN: begin
        if (vanish_c) release_c = 1'b1;
        else          start_c   = 1'b1;
      end

      ST_DATA: begin
        if (vanish_c) begin
          release_c = 1'b1;
        end else if (TRDY == ASSERTED) begin
          if (xfer_c) begin
            off_d = off_q + OFF_ONE;
            if (rd_q) ad_out_d = mem_rdata;
            if (FRAME == DEASSERTED) begin
              release_c = 1'b1;
            end else if (off_q == OFF_LAST) begin
              trdy_d  = DEASSERTED;
              stop_d  = ASSERTED;
              ad_oe_d = 1'b0;
              state_d = ST_DISC;
            end else if (WAIT_STATES != 0) begin
              trdy_d = DEASSERTED;
              cnt_d  = WS_CNT - CNT_ONE;
            end
          end
        end else if (cnt_q == '0) begin
          trdy_d = ASSERTED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DISC: begin
        if (FRAME == DEASSERTED) begin
          stop_d   = DEASSERTED;
          devsel_d = DEASSERTED;
          iam_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (vanish_c) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (release_c) begin
      devsel_d = DEASSERTED;
      trdy_d   = DEASSERTED;
      stop_d   = DEASSERTED;
      ad_oe_d  = 1'b0;
      iam_d    = 1'b0;
      state_d  = ST_IDLE;
    end

    if (claim_c) begin
      devsel_d = ASSERTED;
      iam_d    = 1'b1;
    end

    if (start_c) begin
      state_d = ST_DATA;
      if (rd_now_c) begin
        ad_oe_d  = 1'b1;
        ad_out_d = mem_rdata;
      end
      if (WAIT_STATES == 0) trdy_d = ASSERTED;
      else                  cnt_d  = WS_CNT - CNT_ONE;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      rd_q        <= 1'b0;
      cnt_q       <= '0;
      prev_idle_q <= 1'b0;
      AD_out      <= '0;
      AD_oe       <= 1'b0;
      DEVSEL      <= DEASSERTED;
      TRDY        <= DEASSERTED;
      STOP        <= DEASSERTED;
      I_AM_TARGET <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      prev_idle_q <= (FRAME == DEASSERTED) && (IRDY == DEASSERTED);
      AD_out      <= ad_out_d;
      AD_oe       <= ad_oe_d;
      DEVSEL      <= devsel_d;
      TRDY        <= trdy_d;
      STOP        <= stop_d;
      I_AM_TARGET <= iam_d;
    end
  end

endmodule

// File: tb/tb_pci_simple_target.sv
// Directed bench: two targets on one bus (no-wait at 0x1000, two-wait at 0x3000).
module tb_pci_simple_target;
  import pci_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        FRAME, IRDY;
  logic [31:0] AD_in;
  logic [3:0]  CBE;

  logic [31:0] ad_out0, ad_out1;
  logic        ad_oe0, ad_oe1, devsel0, devsel1, trdy0, trdy1, stop0, stop1, iam0, iam1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pci_simple_target #(
    .BASE_ADDR(32'h0000_1000), .ADDR_BITS(3), .DEVSEL_DELAY(1), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .FRAME(FRAME), .IRDY(IRDY), .AD_in(AD_in), .CBE(CBE),
    .AD_out(ad_out0), .AD_oe(ad_oe0), .DEVSEL(devsel0), .TRDY(trdy0), .STOP(stop0),
    .I_AM_TARGET(iam0)
  );

  pci_simple_target #(
    .BASE_ADDR(32'h0000_3000), .ADDR_BITS(3), .DEVSEL_DELAY(1), .WAIT_STATES(2)
  ) dut1 (
    .clk(clk), .rst(rst), .FRAME(FRAME), .IRDY(IRDY), .AD_in(AD_in), .CBE(CBE),
    .AD_out(ad_out1), .AD_oe(ad_oe1), .DEVSEL(devsel1), .TRDY(trdy1), .STOP(stop1),
    .I_AM_TARGET(iam1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic trdy_of(input int w);
    return (w == 0) ? trdy0 : trdy1;
  endfunction

  function automatic logic devsel_of(input int w);
    return (w == 0) ? devsel0 : devsel1;
  endfunction

  function automatic logic [31:0] ad_out_of(input int w);
    return (w == 0) ? ad_out0 : ad_out1;
  endfunction

  task automatic idle();
    FRAME = 1'b1; IRDY = 1'b1; AD_in = '0; CBE = 4'h0;
    tick();
  endtask

  // Single-phase write; waits (bounded) for TRDY, then completes the transfer.
  task automatic bus_write(input int w, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be_n);
    logic got;
    FRAME = 1'b0; IRDY = 1'b1; AD_in = addr; CBE = CMD_MEM_WRITE;
    tick();
    FRAME = 1'b1; IRDY = 1'b0; AD_in = data; CBE = be_n;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (trdy_of(w) == ASSERTED) got = 1'b1;
    end
    check1("wr_trdy_seen", got, 1'b1);
    check1("wr_devsel_claim", devsel_of(w), ASSERTED);
    tick();
    check1("wr_devsel_release", devsel_of(w), DEASSERTED);
    idle();
  endtask

  // Single-phase read; returns the word presented while TRDY is asserted.
  task automatic bus_read(input int w, input logic [31:0] addr, output logic [31:0] data);
    logic got;
    FRAME = 1'b0; IRDY = 1'b1; AD_in = addr; CBE = CMD_MEM_READ;
    tick();
    FRAME = 1'b1; IRDY = 1'b0; AD_in = '0; CBE = 4'h0;
    got  = 1'b0;
    data = 'x;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (trdy_of(w) == ASSERTED) begin
        got  = 1'b1;
        data = ad_out_of(w);
      end
    end
    check1("rd_trdy_seen", got, 1'b1);
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rdata;

    rst = 1'b1; FRAME = 1'b1; IRDY = 1'b1; AD_in = '0; CBE = 4'h0;
    tick();
    tick();
    check1("rst_devsel", devsel0, DEASSERTED);
    check1("rst_trdy", trdy0, DEASSERTED);
    check1("rst_stop", stop0, DEASSERTED);
    check1("rst_ad_oe", ad_oe0, 1'b0);
    check1("rst_iam", iam0, 1'b0);
    check32("rst_ad_out", ad_out0, 32'h0);
    rst = 1'b0;
    idle();

    // Single write at window base.
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_1000; CBE = CMD_MEM_WRITE;
    tick();
    check1("w1_A_devsel", devsel0, DEASSERTED);
    FRAME = 1'b1; IRDY = 1'b0; AD_in = 32'hDEAD_BEEF; CBE = 4'b0000;
    tick();
    check1("w1_A1_devsel", devsel0, ASSERTED);
    check1("w1_A1_trdy", trdy0, ASSERTED);
    check1("w1_A1_iam", iam0, 1'b1);
    tick();
    check1("w1_A2_devsel", devsel0, DEASSERTED);
    check1("w1_A2_trdy", trdy0, DEASSERTED);
    check1("w1_A2_iam", iam0, 1'b0);
    idle();
    bus_read(0, 32'h0000_1000, rdata);
    check32("w1_mem0", rdata, 32'hDEAD_BEEF);

    // Read burst of three from offset 1.
    bus_write(0, 32'h0000_1004, 32'h11, 4'b0000);
    bus_write(0, 32'h0000_1008, 32'h22, 4'b0000);
    bus_write(0, 32'h0000_100C, 32'h33, 4'b0000);
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_1004; CBE = CMD_MEM_READ;
    tick();
    check1("rb_A_ad_oe", ad_oe0, 1'b0);
    FRAME = 1'b0; IRDY = 1'b0; AD_in = '0; CBE = 4'b0000;
    tick();
    check1("rb_A1_ad_oe", ad_oe0, 1'b1);
    check1("rb_A1_trdy", trdy0, ASSERTED);
    check32("rb_A1_data", ad_out0, 32'h11);
    tick();
    check32("rb_A2_data", ad_out0, 32'h22);
    check1("rb_A2_trdy", trdy0, ASSERTED);
    tick();
    check32("rb_A3_data", ad_out0, 32'h33);
    FRAME = 1'b1;
    tick();
    check1("rb_end_ad_oe", ad_oe0, 1'b0);
    check1("rb_end_devsel", devsel0, DEASSERTED);
    check1("rb_end_trdy", trdy0, DEASSERTED);
    idle();

    // Byte enables with two wait states and an initiator wait.
    bus_write(1, 32'h0000_3008, 32'h1234_5678, 4'b0000);
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_3008; CBE = CMD_MEM_WRITE;
    tick();
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'hAABB_CCDD; CBE = 4'b1100;
    tick();
    check1("be_A1_devsel", devsel1, ASSERTED);
    check1("be_A1_trdy", trdy1, DEASSERTED);
    tick();
    check1("be_A2_trdy", trdy1, DEASSERTED);
    tick();
    check1("be_A3_trdy", trdy1, ASSERTED);
    tick();
    check1("be_A4_trdy_hold", trdy1, ASSERTED);
    check1("be_A4_iam", iam1, 1'b1);
    check1("be_other_devsel", devsel0, DEASSERTED);
    FRAME = 1'b1; IRDY = 1'b0;
    tick();
    check1("be_A5_devsel", devsel1, DEASSERTED);
    idle();
    bus_read(1, 32'h0000_3008, rdata);
    check32("be_word", rdata, 32'h1234_CCDD);

    // Disconnect at the last word of the window.
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_101C; CBE = CMD_MEM_WRITE;
    tick();
    FRAME = 1'b0; IRDY = 1'b0; AD_in = 32'hCAFE_F00D; CBE = 4'b0000;
    tick();
    check1("dc_A1_trdy", trdy0, ASSERTED);
    tick();
    check1("dc_A2_trdy", trdy0, DEASSERTED);
    check1("dc_A2_stop", stop0, ASSERTED);
    check1("dc_A2_devsel", devsel0, ASSERTED);
    FRAME = 1'b1; IRDY = 1'b0; AD_in = 32'h5555_5555;
    tick();
    check1("dc_A3_stop", stop0, DEASSERTED);
    check1("dc_A3_devsel", devsel0, DEASSERTED);
    check1("dc_A3_iam", iam0, 1'b0);
    idle();
    bus_read(0, 32'h0000_101C, rdata);
    check32("dc_word7", rdata, 32'hCAFE_F00D);
    bus_read(0, 32'h0000_1000, rdata);
    check32("dc_no_wrap", rdata, 32'hDEAD_BEEF);

    // Miss, then a normally claimed hit.
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_2000; CBE = CMD_MEM_WRITE;
    tick();
    FRAME = 1'b1; IRDY = 1'b0; AD_in = 32'hFFFF_FFFF; CBE = 4'b0000;
    tick();
    check1("miss_A1_devsel0", devsel0, DEASSERTED);
    check1("miss_A1_devsel1", devsel1, DEASSERTED);
    tick();
    check1("miss_A2_devsel0", devsel0, DEASSERTED);
    check1("miss_A2_trdy0", trdy0, DEASSERTED);
    idle();
    bus_read(0, 32'h0000_1000, rdata);
    check32("miss_mem_kept", rdata, 32'hDEAD_BEEF);
    bus_write(0, 32'h0000_1000, 32'h0BAD_F00D, 4'b0000);
    bus_read(0, 32'h0000_1000, rdata);
    check32("hit_after_miss", rdata, 32'h0BAD_F00D);

    // Reset during a read data phase.
    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_1004; CBE = CMD_MEM_READ;
    tick();
    FRAME = 1'b0; IRDY = 1'b0; AD_in = '0; CBE = 4'b0000;
    tick();
    check1("rr_A1_ad_oe", ad_oe0, 1'b1);
    rst = 1'b1;
    tick();
    check1("rr_devsel", devsel0, DEASSERTED);
    check1("rr_trdy", trdy0, DEASSERTED);
    check1("rr_stop", stop0, DEASSERTED);
    check1("rr_ad_oe", ad_oe0, 1'b0);
    check1("rr_iam", iam0, 1'b0);
    rst = 1'b0;
    idle();
    bus_read(0, 32'h0000_1004, rdata);
    check32("rr_mem1_zero", rdata, 32'h0);
    bus_read(0, 32'h0000_101C, rdata);
    check32("rr_mem7_zero", rdata, 32'h0);
    bus_read(1, 32'h0000_3008, rdata);
    check32("rr_dut1_zero", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
